wav_dfi_phy_hs_responder: RTL
=============================

# wav_dfi_phy_hs_responder

PHY-side synthesizable responder for the DFI update and low-power handshakes; it is the opposite end of the memory-controller-side DFI driver. It acknowledges MC-initiated `ctrlupd_req`, `lp_ctrl_req` and `lp_data_req`, and initiates PHY updates (`phyupd_req`/`phyupd_type`) on behalf of the PHY core. PHY-master signals are outside this block's scope.

## Interface
Parameters:
- ACK_DLY, 2, cycles from first sampled req-high edge to ack-high; legal range 1..15
- CNT_W, 4, delay counter width; must hold ACK_DLY

Ports:
- clock  in  1  DFI clock, all logic on posedge
- reset  in  1  synchronous, active-high
- ctrlupd_req  in  1  MC update request
- ctrlupd_ack  out  1  update acknowledge
- lp_ctrl_req  in  1  control low-power request
- lp_ctrl_wakeup  in  6  control wakeup code
- lp_ctrl_ack  out  1  control LP acknowledge
- lp_data_req  in  1  data low-power request
- lp_data_wakeup  in  6  data wakeup code
- lp_data_ack  out  1  data LP acknowledge
- phyupd_req  out  1  PHY update request
- phyupd_type  out  2  PHY update type
- phyupd_ack  in  1  MC grant of PHY update
- core_upd_allow  in  1  core accepts ctrlupd now
- core_lp_allow  in  1  core accepts LP entry now
- core_phyupd_start  in  1  core pulse: start PHY update
- core_phyupd_type  in  2  type captured with start
- core_phyupd_done  in  1  core pulse: update finished
- core_ctrlupd_active  out  1  ctrlupd window open
- core_phyupd_grant  out  1  PHY update window open
- core_lp_ctrl_active / core_lp_data_active  out  1 each  LP window open
- core_lp_ctrl_wakeup / core_lp_data_wakeup  out  6 each  latched wakeup codes

## Operation
- All outputs registered; reset drives every output to 0, all FSMs to idle, counters and latched codes to 0.
- Update FSM (ctrlupd and phyupd mutually exclusive): U_IDLE, CU_WAIT, CU_ACK, PU_REQ, PU_GRANT, PU_DROP.
  - U_IDLE: ctrlupd_req & core_upd_allow -> CU_WAIT, counter = ACK_DLY-1. Else core_phyupd_start -> PU_REQ, latch type. Both on same edge: ctrlupd wins; start is dropped (core must re-pulse).
  - ctrlupd_req high with core_upd_allow low: remain U_IDLE, no ack; re-evaluated every cycle.
  - CU_WAIT: req low -> U_IDLE, no ack (abort). Counter 0 -> CU_ACK. Otherwise decrement.
  - CU_ACK: ctrlupd_ack = core_ctrlupd_active = 1; req low -> U_IDLE.
  - PU_REQ: phyupd_req=1, phyupd_type=latched; phyupd_ack -> PU_GRANT. ctrlupd_req ignored in all PU_* states.
  - PU_GRANT: phyupd_req=1, core_phyupd_grant=1; core_phyupd_done -> PU_DROP.
  - PU_DROP: phyupd_req=0, grant=0; phyupd_ack low -> U_IDLE.
  - Req still high when returning to U_IDLE is serviced as new.
- LP FSMs (ctrl and data independent, identical): L_IDLE, L_WAIT, L_ACK.
  - L_IDLE: req & core_lp_allow -> L_WAIT, latch wakeup, counter = ACK_DLY-1.
  - L_WAIT: req low -> L_IDLE, no ack. Counter 0 -> L_ACK.
  - L_ACK: ack=1, core_lp_*_active=1, wakeup re-latched every cycle req high; req low -> L_IDLE, latched code held.
  - LP FSMs never gated by update FSM.

## Timing
- Ack high exactly ACK_DLY edges after the first edge sampling req high (ACK_DLY=2: sampled at E0, ack visible after E2).
- Ack low after the first edge sampling req low (1-cycle deassert latency).
- phyupd_req high 1 cycle after start sampled; grant high 1 cycle after phyupd_ack sampled; req/grant low 1 cycle after done sampled.
- Reset asserted mid-handshake: all outputs 0 after that edge; held req restarts from idle after release.

## Test plan
- ACK_DLY=2, core_upd_allow=1, ctrlupd_req high 10 cycles -> ack high from edge 2 through 1 cycle after req low; core_ctrlupd_active matches.
- ctrlupd_req high 1 cycle (ACK_DLY=3) -> ctrlupd_ack never asserts; FSM returns U_IDLE.
- core_phyupd_start type=2'b01, phyupd_ack after 5 cycles, done after 4 -> phyupd_req/type=01 held, grant 4 cycles, req drops, idle after ack low.
- ctrlupd_req and core_phyupd_start same edge -> ctrlupd acked, phyupd_req stays 0; ctrlupd_req during PU_GRANT -> no ack until PU_DROP completes.
- lp_ctrl_req wakeup=6'h05, changed to 6'h0A while acked; lp_data_req concurrent -> both acks independent, core_lp_ctrl_wakeup 05 then 0A.
- reset pulse in CU_ACK and L_ACK -> all outputs 0 next edge; held requests re-acked ACK_DLY edges after reset release.

Source files
------------

// File: rtl/wav_dfi_phy_hs_responder.sv
// wav_dfi_phy_hs_responder
//   PHY-side responder for the DFI update and low-power handshakes.
//   - Acknowledges MC ctrlupd_req after ACK_DLY cycles while the core allows it.
//   - Drives phyupd_req/phyupd_type on behalf of the PHY core and opens the
//     grant window once the MC returns phyupd_ack.
//   - Acknowledges lp_ctrl_req / lp_data_req independently and latches the
//     wakeup codes for the core.
// Ports:
//   clock, reset                : DFI clock, synchronous active-high reset
//   ctrlupd_req / ctrlupd_ack   : MC-initiated update handshake
//   lp_ctrl_* / lp_data_*       : low-power request, wakeup code, acknowledge
//   phyupd_req/type/ack         : PHY-initiated update handshake
//   core_*                      : PHY core side permissions, pulses and status
// All outputs are registered and cleared by reset.

module wav_dfi_phy_hs_lp_fsm #(
  parameter int unsigned ACK_DLY = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic       allow,
  input  logic [5:0] wakeup,
  output logic       ack,
  output logic       active,
  output logic [5:0] wakeup_q
);

  typedef enum logic [1:0] {L_IDLE, L_WAIT, L_ACK} lp_state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_DLY - 1);

  lp_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [5:0]       wk_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wk_nx    = wakeup_q;
    case (state)
      L_IDLE: if (req && allow) begin
        state_nx = L_WAIT;
        cnt_nx   = CNT_LOAD;
        wk_nx    = wakeup;
      end
      L_WAIT: begin
        if (!req)            state_nx = L_IDLE;
        else if (cnt == '0)  state_nx = L_ACK;
        else                 cnt_nx   = cnt - CNT_W'(1);
      end
      L_ACK: begin
        // code tracks the MC while acked; held once req drops
        if (!req) state_nx = L_IDLE;
        else      wk_nx    = wakeup;
      end
      default: state_nx = L_IDLE;
    endcase
  end

  // Outputs are registered from the next state so ack appears on the same
  // edge the FSM enters L_ACK.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= L_IDLE;
      cnt      <= '0;
      wakeup_q <= '0;
      ack      <= 1'b0;
      active   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      wakeup_q <= wk_nx;
      ack      <= (state_nx == L_ACK);
      active   <= (state_nx == L_ACK);
    end
  end

endmodule

module wav_dfi_phy_hs_responder #(
  parameter int unsigned ACK_DLY = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ctrlupd_req,
  output logic       ctrlupd_ack,
  input  logic       lp_ctrl_req,
  input  logic [5:0] lp_ctrl_wakeup,
  output logic       lp_ctrl_ack,
  input  logic       lp_data_req,
  input  logic [5:0] lp_data_wakeup,
  output logic       lp_data_ack,
  output logic       phyupd_req,
  output logic [1:0] phyupd_type,
  input  logic       phyupd_ack,
  input  logic       core_upd_allow,
  input  logic       core_lp_allow,
  input  logic       core_phyupd_start,
  input  logic [1:0] core_phyupd_type,
  input  logic       core_phyupd_done,
  output logic       core_ctrlupd_active,
  output logic       core_phyupd_grant,
  output logic       core_lp_ctrl_active,
  output logic       core_lp_data_active,
  output logic [5:0] core_lp_ctrl_wakeup,
  output logic [5:0] core_lp_data_wakeup
);

  typedef enum logic [2:0] {
    U_IDLE, CU_WAIT, CU_ACK, PU_REQ, PU_GRANT, PU_DROP
  } upd_state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_DLY - 1);

  upd_state_t       u_state, u_next;
  logic [CNT_W-1:0] u_cnt, u_cnt_next;
  logic [1:0]       u_type, u_type_next;
  logic             pu_window;

  always_comb begin
    u_next      = u_state;
    u_cnt_next  = u_cnt;
    u_type_next = u_type;
    case (u_state)
      U_IDLE: begin
        // ctrlupd has priority; a coincident start pulse is discarded
        if (ctrlupd_req && core_upd_allow) begin
          u_next     = CU_WAIT;
          u_cnt_next = CNT_LOAD;
        end else if (core_phyupd_start) begin
          u_next      = PU_REQ;
          u_type_next = core_phyupd_type;
        end
      end
      CU_WAIT: begin
        if (!ctrlupd_req)      u_next     = U_IDLE;
        else if (u_cnt == '0)  u_next     = CU_ACK;
        else                   u_cnt_next = u_cnt - CNT_W'(1);
      end
      CU_ACK:   if (!ctrlupd_req)      u_next = U_IDLE;
      PU_REQ:   if (phyupd_ack)        u_next = PU_GRANT;
      PU_GRANT: if (core_phyupd_done)  u_next = PU_DROP;
      PU_DROP:  if (!phyupd_ack)       u_next = U_IDLE;
      default:  u_next = U_IDLE;
    endcase
  end

  assign pu_window = (u_next == PU_REQ) || (u_next == PU_GRANT);

  always_ff @(posedge clock) begin
    if (reset) begin
      u_state             <= U_IDLE;
      u_cnt               <= '0;
      u_type              <= '0;
      ctrlupd_ack         <= 1'b0;
      core_ctrlupd_active <= 1'b0;
      phyupd_req          <= 1'b0;
      phyupd_type         <= '0;
      core_phyupd_grant   <= 1'b0;
    end else begin
      u_state             <= u_next;
      u_cnt               <= u_cnt_next;
      u_type              <= u_type_next;
      ctrlupd_ack         <= (u_next == CU_ACK);
      core_ctrlupd_active <= (u_next == CU_ACK);
      phyupd_req          <= pu_window;
      phyupd_type         <= pu_window ? u_type_next : 2'b00;
      core_phyupd_grant   <= (u_next == PU_GRANT);
    end
  end

  wav_dfi_phy_hs_lp_fsm #(.ACK_DLY(ACK_DLY), .CNT_W(CNT_W)) u_lp_ctrl (
    .clock    (clock),
    .reset    (reset),
    .req      (lp_ctrl_req),
    .allow    (core_lp_allow),
    .wakeup   (lp_ctrl_wakeup),
    .ack      (lp_ctrl_ack),
    .active   (core_lp_ctrl_active),
    .wakeup_q (core_lp_ctrl_wakeup)
  );

  wav_dfi_phy_hs_lp_fsm #(.ACK_DLY(ACK_DLY), .CNT_W(CNT_W)) u_lp_data (
    .clock    (clock),
    .reset    (reset),
    .req      (lp_data_req),
    .allow    (core_lp_allow),
    .wakeup   (lp_data_wakeup),
    .ack      (lp_data_ack),
    .active   (core_lp_data_active),
    .wakeup_q (core_lp_data_wakeup)
  );

endmodule
